// File: rtl/game_pkg.sv
// Breakout game controller: shared state encodings and default constants.
// Ball and renderer blocks import these encodings as well.
package game_pkg;

  typedef enum logic [2:0] {
    MAIN_MENU = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    LIFE_LOST = 3'd3,
    END_WIN   = 3'd4,
    END_LOSE  = 3'd5
  } state_t;

  localparam int DEF_TICK_DIV      = 833333;
  localparam int DEF_NUM_BRICKS    = 40;
  localparam int DEF_RESPAWN_TICKS = 60;
  localparam int DEF_START_LIVES   = 3;

endpackage

// File: rtl/game_controller_tick_gen.sv
// Ball-step divider: counts 0..TICK_DIV-1, tick on the last count.
// clear restarts the period so each state sees a full first tick.
module tick_gen
  import game_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_controller.sv
// Breakout game controller: menu/serve/play/life-lost/end sequencing,
// lives, score and brick bookkeeping, ball step and hold control.
module game_controller
  import game_pkg::*;
#(
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int NUM_BRICKS    = DEF_NUM_BRICKS,
  parameter int RESPAWN_TICKS = DEF_RESPAWN_TICKS,
  parameter int START_LIVES   = DEF_START_LIVES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_space,
  input  logic       brick_hit,
  input  logic       ball_miss,
  output logic [2:0] state,
  output logic       ball_step,
  output logic       ball_hold,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic [7:0] bricks_left
);

  localparam logic [1:0] LIVES0 = 2'(START_LIVES);
  localparam logic [7:0] BRICKS0 = 8'(NUM_BRICKS);
  localparam logic [7:0] RESP_LAST = 8'(RESPAWN_TICKS - 1);

  state_t     st, nxt;
  logic       key_q, armed, ev;
  logic       tick, chg, en;
  logic [7:0] resp;
  logic [1:0] lv_n;
  logic [7:0] sc_n, br_n;

  // armed blocks a key already held when reset is released
  assign ev = key_space & ~key_q & armed;

  assign chg = (nxt != st);
  assign en = (st == PLAY) || (st == LIFE_LOST);
  assign state = st;
  assign ball_step = tick && (st == PLAY);
  assign ball_hold = (st == MAIN_MENU) || (st == SERVE) ||
                     (st == LIFE_LOST);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (chg),
    .enable(en),
    .tick  (tick)
  );

  always_comb begin
    nxt = st;
    lv_n = lives;
    sc_n = score;
    br_n = bricks_left;
    case (st)
      MAIN_MENU: if (ev) begin
        nxt = SERVE;
        lv_n = LIVES0;
        sc_n = '0;
        br_n = BRICKS0;
      end
      SERVE: if (ev) nxt = PLAY;
      PLAY: begin
        if (brick_hit && bricks_left != 8'd0) begin
          br_n = bricks_left - 8'd1;
          if (score != 8'hff) sc_n = score + 8'd1;
        end
        if (brick_hit && bricks_left == 8'd1) begin
          nxt = END_WIN;
        end else if (ball_miss) begin
          nxt = LIFE_LOST;
          if (lives != 2'd0) lv_n = lives - 2'd1;
        end
      end
      LIFE_LOST: begin
        if (lives == 2'd0) nxt = END_LOSE;
        else if (tick && resp == RESP_LAST) nxt = SERVE;
      end
      END_WIN, END_LOSE: if (ev) nxt = MAIN_MENU;
      default: nxt = MAIN_MENU;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st <= MAIN_MENU;
      key_q <= 1'b0;
      armed <= 1'b0;
      resp <= '0;
      lives <= '0;
      score <= '0;
      bricks_left <= '0;
    end else begin
      st <= nxt;
      key_q <= key_space;
      armed <= armed | ~key_space;
      lives <= lv_n;
      score <= sc_n;
      bricks_left <= br_n;
      if (chg) resp <= '0;
      else if (st == LIFE_LOST && tick) resp <= resp + 8'd1;
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: stimulus queues cycle-tagged
// expectations, a negedge monitor pops and compares them.
module tb_game_controller;

  localparam logic [2:0] S_MENU = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY = 3'd2;
  localparam logic [2:0] S_LOST = 3'd3;
  localparam logic [2:0] S_WIN = 3'd4;
  localparam logic [2:0] S_LOSE = 3'd5;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       key_space = 1'b0;
  logic       brick_hit = 1'b0;
  logic       ball_miss = 1'b0;
  logic [2:0] state;
  logic       ball_step, ball_hold;
  logic [1:0] lives;
  logic [7:0] score, bricks_left;

  typedef struct {
    int         tag;
    string      name;
    logic [2:0] st;
    logic       step;
    logic       hold;
    logic [1:0] lv;
    logic [7:0] sc;
    logic [7:0] br;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  game_controller #(
    .TICK_DIV     (4),
    .NUM_BRICKS   (2),
    .RESPAWN_TICKS(2),
    .START_LIVES  (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key_space  (key_space),
    .brick_hit  (brick_hit),
    .ball_miss  (ball_miss),
    .state      (state),
    .ball_step  (ball_step),
    .ball_hold  (ball_hold),
    .lives      (lives),
    .score      (score),
    .bricks_left(bricks_left)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial forever begin
    @(negedge clock);
    while (q.size() > 0 && q[0].tag <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.tag < cyc) begin
        errors++;
        $display("FAIL %s: tag %0d never sampled", e.name, e.tag);
      end else if (state !== e.st || ball_step !== e.step ||
                   ball_hold !== e.hold || lives !== e.lv ||
                   score !== e.sc || bricks_left !== e.br) begin
        errors++;
        $display("FAIL %s @%0d: got st=%0d step=%b hold=%b lv=%0d sc=%0d br=%0d, want st=%0d step=%b hold=%b lv=%0d sc=%0d br=%0d",
                 e.name, cyc, state, ball_step, ball_hold, lives,
                 score, bricks_left, e.st, e.step, e.hold, e.lv,
                 e.sc, e.br);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input int d, input string name,
                     input logic [2:0] s, input logic stp,
                     input logic hld, input logic [1:0] lv,
                     input logic [7:0] sc, input logic [7:0] br);
    exp_t e;
    e.tag = cyc + d;
    e.name = name;
    e.st = s;
    e.step = stp;
    e.hold = hld;
    e.lv = lv;
    e.sc = sc;
    e.br = br;
    q.push_back(e);
  endtask

  task automatic press();
    key_space = 1'b1;
    step(1);
    key_space = 1'b0;
    step(1);
  endtask

  initial begin
    step(2);
    chk(0, "reset", S_MENU, 0, 1, 0, 0, 0);
    step(1);
    reset = 1'b1;
    step(1);

    // held key: exactly one menu->serve transition
    for (int d = 1; d <= 10; d++)
      chk(d, "hold_key", S_SERVE, 0, 1, 2, 0, 2);
    key_space = 1'b1;
    step(10);
    key_space = 1'b0;
    step(1);

    // ball_step on cycles 4, 8, 12 of PLAY
    for (int k = 1; k <= 12; k++)
      chk(k, "play_step", S_PLAY, (k % 4 == 0), 0, 2, 0, 2);
    key_space = 1'b1;
    step(1);
    key_space = 1'b0;
    step(11);

    brick_hit = 1'b1;
    chk(1, "hit1", S_PLAY, 0, 0, 2, 1, 1);
    step(1);
    brick_hit = 1'b0;
    step(1);
    brick_hit = 1'b1;
    chk(1, "win", S_WIN, 0, 0, 2, 2, 0);
    step(1);
    brick_hit = 1'b0;
    for (int d = 1; d <= 8; d++)
      chk(d, "win_hold", S_WIN, 0, 0, 2, 2, 0);
    brick_hit = 1'b1;
    ball_miss = 1'b1;
    step(1);
    brick_hit = 1'b0;
    ball_miss = 1'b0;
    step(7);

    chk(1, "win_menu", S_MENU, 0, 1, 2, 2, 0);
    press();
    chk(1, "serve2", S_SERVE, 0, 1, 2, 0, 2);
    press();
    chk(1, "play2", S_PLAY, 0, 0, 2, 0, 2);
    press();

    // miss, respawn after 8 cycles, hit ignored while lost
    ball_miss = 1'b1;
    for (int d = 1; d <= 8; d++)
      chk(d, "lost1", S_LOST, 0, 1, 1, 0, 2);
    chk(9, "respawn", S_SERVE, 0, 1, 1, 0, 2);
    step(1);
    ball_miss = 1'b0;
    brick_hit = 1'b1;
    step(1);
    brick_hit = 1'b0;
    step(7);
    chk(1, "play3", S_PLAY, 0, 0, 1, 0, 2);
    press();
    ball_miss = 1'b1;
    chk(1, "lost0", S_LOST, 0, 1, 0, 0, 2);
    for (int d = 2; d <= 5; d++)
      chk(d, "lose", S_LOSE, 0, 0, 0, 0, 2);
    step(1);
    ball_miss = 1'b0;
    step(4);
    chk(1, "lose_menu", S_MENU, 0, 1, 0, 0, 2);
    press();

    // simultaneous hit and miss, not last brick then last brick
    chk(1, "serve4", S_SERVE, 0, 1, 2, 0, 2);
    press();
    chk(1, "play4", S_PLAY, 0, 0, 2, 0, 2);
    press();
    brick_hit = 1'b1;
    ball_miss = 1'b1;
    chk(1, "both_lost", S_LOST, 0, 1, 1, 1, 1);
    step(1);
    brick_hit = 1'b0;
    ball_miss = 1'b0;
    chk(8, "both_serve", S_SERVE, 0, 1, 1, 1, 1);
    step(8);
    chk(1, "play5", S_PLAY, 0, 0, 1, 1, 1);
    press();
    brick_hit = 1'b1;
    ball_miss = 1'b1;
    chk(1, "both_win", S_WIN, 0, 0, 1, 2, 0);
    step(1);
    brick_hit = 1'b0;
    ball_miss = 1'b0;
    chk(2, "both_win_hold", S_WIN, 0, 0, 1, 2, 0);
    step(3);

    // async reset during PLAY with the key held
    chk(1, "menu6", S_MENU, 0, 1, 1, 2, 0);
    press();
    chk(1, "serve6", S_SERVE, 0, 1, 2, 0, 2);
    press();
    chk(1, "play6", S_PLAY, 0, 0, 2, 0, 2);
    press();
    key_space = 1'b1;
    step(1);
    reset = 1'b0;
    chk(0, "rst_async", S_MENU, 0, 1, 0, 0, 0);
    chk(1, "rst_hold", S_MENU, 0, 1, 0, 0, 0);
    step(2);
    reset = 1'b1;
    for (int d = 1; d <= 5; d++)
      chk(d, "held_at_release", S_MENU, 0, 1, 0, 0, 0);
    step(5);
    key_space = 1'b0;
    step(1);
    chk(1, "repress", S_SERVE, 0, 1, 2, 0, 2);
    press();
    step(2);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: tag %0d left unchecked", e.name, e.tag);
    end
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: stimulus still running at %0t, want done",
               $time);
      $fatal(1, "watchdog");
    end
  end

endmodule
